// File: rtl/bram_stream_writer_if.sv
// Valid/ready word stream from acquisition logic into the BRAM stream writer.
interface bram_stream_writer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;

    // Producer side: drives the word, samples ready.
    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    // Consumer side: samples the word, drives ready.
    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/bram_stream_writer.sv
// Stream-to-BRAM circular buffer writer. Words accepted on the stream are written to BRAM
// Port A one cycle later; write pointer, fill level, frame and drop counters and a sticky
// overflow flag are published for the PS register file.
module bram_stream_writer #(
    parameter int unsigned BRAM_ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter bit          DROP_ON_FULL    = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       ptr_clear,
    input  logic                       ovf_clear,
    bram_stream_writer_if.slave        s_if,
    input  logic [BRAM_ADDR_WIDTH-3:0] rd_ptr,
    output logic                       bram_clk,
    output logic                       bram_rst,
    output logic                       bram_en,
    output logic [3:0]                 bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0]      bram_din,
    output logic [BRAM_ADDR_WIDTH-3:0] wr_ptr,
    output logic [BRAM_ADDR_WIDTH-3:0] fill_level,
    output logic [31:0]                frame_count,
    output logic [BRAM_ADDR_WIDTH-3:0] last_frame_ptr,
    output logic [31:0]                drop_count,
    output logic                       overflow
);
    localparam int unsigned W = BRAM_ADDR_WIDTH - 2;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                       state_q, state_d;
    logic [W-1:0]                 wp_q, wp_d;            // internal next-write index
    logic [W-1:0]                 wr_ptr_q, wr_ptr_d;    // published copy, one cycle behind
    logic [31:0]                  fc_q, fc_d;            // internal frame count
    logic [31:0]                  fc_pub_q, fc_pub_d;
    logic [W-1:0]                 lfp_q, lfp_d;          // internal last-frame pointer
    logic [W-1:0]                 lfp_pub_q, lfp_pub_d;
    logic [31:0]                  drop_q, drop_d;
    logic                         ovf_q, ovf_d;
    logic                         en_q, en_d;
    logic [BRAM_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]        din_q, din_d;

    logic [W-1:0] wp_inc;
    logic         full;
    logic         accept;

    // One slot always stays empty; rd_ptr frees space in the same cycle.
    assign wp_inc       = wp_q + 1'b1;
    assign full         = (wp_inc == rd_ptr);
    assign s_if.s_ready = (state_q == StRun) && (!full || DROP_ON_FULL);
    assign accept       = s_if.s_valid && s_if.s_ready;

    assign bram_clk       = clk;
    assign bram_rst       = rst;
    assign bram_en        = en_q;
    assign bram_we        = {4{en_q}};
    assign bram_addr      = addr_q;
    assign bram_din       = din_q;
    assign wr_ptr         = wr_ptr_q;
    assign fill_level     = wr_ptr_q - rd_ptr;
    assign frame_count    = fc_pub_q;
    assign last_frame_ptr = lfp_pub_q;
    assign drop_count     = drop_q;
    assign overflow       = ovf_q;

    // Next-state: capture FSM, BRAM write request, pointers, counters and overflow.
    always_comb begin
        state_d   = state_q;
        wp_d      = wp_q;
        fc_d      = fc_q;
        lfp_d     = lfp_q;
        drop_d    = drop_q;
        ovf_d     = ovf_q & ~ovf_clear;
        en_d      = 1'b0;
        addr_d    = addr_q;
        din_d     = din_q;
        // Published values trail the internal ones so software never sees uncommitted data.
        wr_ptr_d  = wp_q;
        fc_pub_d  = fc_q;
        lfp_pub_d = lfp_q;

        case (state_q)
            StIdle: begin
                if (ptr_clear) begin
                    wp_d   = '0;
                    fc_d   = '0;
                    drop_d = '0;
                end
                if (enable) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (accept && !full) begin
                    en_d   = 1'b1;
                    addr_d = {wp_q, 2'b00};
                    din_d  = s_if.s_data;
                    wp_d   = wp_inc;
                    if (s_if.s_last) begin
                        fc_d  = fc_q + 32'd1;
                        lfp_d = wp_inc;
                    end
                end
                // Either a dropped word or a refused one counts as overflow.
                if (s_if.s_valid && full) begin
                    ovf_d = 1'b1;
                    if (accept && (drop_q != 32'hFFFF_FFFF)) begin
                        drop_d = drop_q + 32'd1;
                    end
                end
                if (!enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset abandons any in-flight write immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            wp_q      <= '0;
            wr_ptr_q  <= '0;
            fc_q      <= '0;
            fc_pub_q  <= '0;
            lfp_q     <= '0;
            lfp_pub_q <= '0;
            drop_q    <= '0;
            ovf_q     <= 1'b0;
            en_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            wp_q      <= wp_d;
            wr_ptr_q  <= wr_ptr_d;
            fc_q      <= fc_d;
            fc_pub_q  <= fc_pub_d;
            lfp_q     <= lfp_d;
            lfp_pub_q <= lfp_pub_d;
            drop_q    <= drop_d;
            ovf_q     <= ovf_d;
            en_q      <= en_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
        end
    end
endmodule

// File: tb/tb_bram_stream_writer.sv
// Bench for bram_stream_writer: two instances (drop-on-full and backpressure) share one
// stimulus; a buffer-level model predicts every output and is checked each cycle.
module tb_bram_stream_writer;
    localparam int DEPTH = 16;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        enable    = 1'b0;
    logic        ptr_clear = 1'b0;
    logic        ovf_clear = 1'b0;
    logic [31:0] s_data    = '0;
    logic        s_valid   = 1'b0;
    logic        s_last    = 1'b0;
    logic [3:0]  rd_ptr    = '0;

    logic [1:0]       rdy, bclk, brst, ben, ovf;
    logic [1:0][3:0]  bwe, wrp, fill, lfp;
    logic [1:0][5:0]  baddr;
    logic [1:0][31:0] bdin, fcnt, dcnt;

    bram_stream_writer_if #(.DATA_WIDTH(32)) sif0 ();
    bram_stream_writer_if #(.DATA_WIDTH(32)) sif1 ();

    assign sif0.s_data  = s_data;
    assign sif0.s_valid = s_valid;
    assign sif0.s_last  = s_last;
    assign sif1.s_data  = s_data;
    assign sif1.s_valid = s_valid;
    assign sif1.s_last  = s_last;
    assign rdy[0] = sif0.s_ready;
    assign rdy[1] = sif1.s_ready;

    bram_stream_writer #(.BRAM_ADDR_WIDTH(6), .DATA_WIDTH(32), .DROP_ON_FULL(1'b1)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .ptr_clear(ptr_clear), .ovf_clear(ovf_clear),
        .s_if(sif0), .rd_ptr(rd_ptr), .bram_clk(bclk[0]), .bram_rst(brst[0]),
        .bram_en(ben[0]), .bram_we(bwe[0]), .bram_addr(baddr[0]), .bram_din(bdin[0]),
        .wr_ptr(wrp[0]), .fill_level(fill[0]), .frame_count(fcnt[0]),
        .last_frame_ptr(lfp[0]), .drop_count(dcnt[0]), .overflow(ovf[0])
    );

    bram_stream_writer #(.BRAM_ADDR_WIDTH(6), .DATA_WIDTH(32), .DROP_ON_FULL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .ptr_clear(ptr_clear), .ovf_clear(ovf_clear),
        .s_if(sif1), .rd_ptr(rd_ptr), .bram_clk(bclk[1]), .bram_rst(brst[1]),
        .bram_en(ben[1]), .bram_we(bwe[1]), .bram_addr(baddr[1]), .bram_din(bdin[1]),
        .wr_ptr(wrp[1]), .fill_level(fill[1]), .frame_count(fcnt[1]),
        .last_frame_ptr(lfp[1]), .drop_count(dcnt[1]), .overflow(ovf[1])
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int i, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[inst%0d] t=%0t: got %0h, expected %0h", name, i, $time, act, exp);
    endtask

    // ---------------- behavioural model (instance 0 drops, instance 1 backpressures) -----
    bit          m_run  [2];
    int          m_wp   [2];   // slots written so far, modulo DEPTH
    int          m_wr   [2];   // published write index
    logic [31:0] m_fc   [2];
    logic [31:0] m_fcp  [2];
    int          m_lfp  [2];
    int          m_lfpp [2];
    logic [31:0] m_drop [2];
    bit          m_ovf  [2];
    bit          m_wv   [2];   // a BRAM write is expected to be on the port now
    int          m_wa   [2];
    logic [31:0] m_wd   [2];

    function automatic bit m_full(input int i);
        return ((m_wp[i] + 1) % DEPTH) == int'(rd_ptr);
    endfunction

    function automatic bit m_ready(input int i);
        return m_run[i] && (!m_full(i) || (i == 0));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_wp[i] = 0; m_wr[i] = 0; m_fc[i] = 0; m_fcp[i] = 0;
            m_lfp[i] = 0; m_lfpp[i] = 0; m_drop[i] = 0; m_ovf[i] = 0; m_wv[i] = 0;
            m_wa[i] = 0; m_wd[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        bit full, acc, ev;
        full = m_full(i);
        acc  = s_valid && m_ready(i);
        ev   = 0;
        m_wr[i]   = m_wp[i];
        m_fcp[i]  = m_fc[i];
        m_lfpp[i] = m_lfp[i];
        m_wv[i]   = 0;
        if (acc && !full) begin
            m_wv[i] = 1;
            m_wa[i] = m_wp[i] * 4;
            m_wd[i] = s_data;
            m_wp[i] = (m_wp[i] + 1) % DEPTH;
            if (s_last) begin
                m_fc[i]  = m_fc[i] + 1;
                m_lfp[i] = m_wp[i];
            end
        end
        if (m_run[i] && s_valid && full) begin
            ev = 1;
            if (acc && m_drop[i] != 32'hFFFF_FFFF) m_drop[i] = m_drop[i] + 1;
        end
        m_ovf[i] = (m_ovf[i] && !ovf_clear) || ev;
        if (!m_run[i] && ptr_clear) begin
            m_wp[i] = 0; m_fc[i] = 0; m_drop[i] = 0;
        end
        m_run[i] = enable;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else for (int i = 0; i < 2; i++) model_step(i);
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("s_ready", i, rdy[i], m_ready(i));
            chk("fill_level", i, fill[i], (m_wr[i] - int'(rd_ptr) + DEPTH) % DEPTH);
            chk("wr_ptr", i, wrp[i], m_wr[i]);
            chk("frame_count", i, fcnt[i], m_fcp[i]);
            chk("last_frame_ptr", i, lfp[i], m_lfpp[i]);
            chk("drop_count", i, dcnt[i], m_drop[i]);
            chk("overflow", i, ovf[i], m_ovf[i]);
            chk("bram_en", i, ben[i], m_wv[i]);
            chk("bram_we", i, bwe[i], m_wv[i] ? 4'hF : 4'h0);
            chk("bram_clk", i, bclk[i], clk);
            chk("bram_rst", i, brst[i], rst);
            if (m_wv[i]) begin
                chk("bram_addr", i, baddr[i], m_wa[i]);
                chk("bram_din", i, bdin[i], m_wd[i]);
            end
        end
    end

    // ---------------- stimulus with hand-computed literal expectations ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        s_valid = 0; s_last = 0; ptr_clear = 0; ovf_clear = 0;
    endtask

    task automatic do_reset();
        rst = 1; enable = 0; rd_ptr = 0; idle_in();
        repeat (2) tick();
        rst = 0;
        tick();
    endtask

    task automatic both(input string name, input logic [63:0] a0, input logic [63:0] a1,
                        input logic [63:0] exp);
        chk(name, 0, a0, exp);
        chk(name, 1, a1, exp);
    endtask

    initial begin
        // Reset state
        do_reset();
        both("rst_wr_ptr", wrp[0], wrp[1], 0);
        both("rst_bram_en", ben[0], ben[1], 0);
        both("rst_s_ready", rdy[0], rdy[1], 0);

        // Five back-to-back words, each written one cycle after accept
        enable = 1;
        tick();
        for (int k = 0; k < 5; k++) begin
            s_valid = 1; s_data = 32'hA0 + k;
            tick();
            both("wr1_en", ben[0], ben[1], 1);
            both("wr1_addr", baddr[0], baddr[1], 4 * k);
            both("wr1_din", bdin[0], bdin[1], 32'hA0 + k);
        end
        s_valid = 0;
        tick();
        both("wr1_wr_ptr", wrp[0], wrp[1], 5);
        both("wr1_fill", fill[0], fill[1], 5);

        // Overfill with rd_ptr = 0: drop vs backpressure
        do_reset();
        enable = 1;
        tick();
        for (int k = 0; k < 20; k++) begin
            s_valid = 1; s_data = 32'hB00 + k;
            tick();
        end
        s_valid = 0;
        repeat (2) tick();
        chk("ovf_drop_count", 0, dcnt[0], 5);
        chk("ovf_drop_count", 1, dcnt[1], 0);
        both("ovf_flag", ovf[0], ovf[1], 1);
        both("ovf_wr_ptr", wrp[0], wrp[1], 15);
        chk("full_ready", 1, rdy[1], 0);
        chk("full_ready", 0, rdy[0], 1);
        ovf_clear = 1;
        tick();
        ovf_clear = 0;
        both("ovf_cleared", ovf[0], ovf[1], 0);
        chk("drop_hold", 0, dcnt[0], 5);

        // Consumer frees space: ready returns combinationally, writes wrap
        rd_ptr = 4;
        #1;
        chk("free_ready", 1, rdy[1], 1);
        for (int k = 0; k < 4; k++) begin
            logic [5:0] wrap_addr [4];
            wrap_addr = '{6'h3C, 6'h00, 6'h04, 6'h08};
            s_valid = 1; s_data = 32'hC0 + k;
            tick();
            both("wrap_addr", baddr[0], baddr[1], wrap_addr[k]);
        end
        s_valid = 0;
        repeat (2) tick();
        both("wrap_wr_ptr", wrp[0], wrp[1], 3);

        // Full again (wp=3, rd=4): clear and new overflow in the same cycle
        s_valid = 1; ovf_clear = 1;
        tick();
        idle_in();
        both("ovf_set_wins", ovf[0], ovf[1], 1);
        chk("drop_again", 0, dcnt[0], 6);

        // Three 4-word frames
        do_reset();
        enable = 1;
        tick();
        for (int f = 0; f < 3; f++) begin
            for (int w = 0; w < 4; w++) begin
                s_valid = 1; s_last = (w == 3); s_data = 32'hD00 + 4 * f + w;
                tick();
            end
        end
        idle_in();
        repeat (2) tick();
        both("frame_count", fcnt[0], fcnt[1], 3);
        both("last_frame_ptr", lfp[0], lfp[1], 12);

        // Disable on the accept edge of word 7, then ptr_clear in IDLE and in RUN
        do_reset();
        enable = 1;
        tick();
        for (int k = 0; k < 7; k++) begin
            s_valid = 1; s_data = 32'hE0 + k;
            if (k == 6) enable = 0;
            tick();
        end
        s_valid = 0;
        both("dis_last_en", ben[0], ben[1], 1);
        both("dis_last_addr", baddr[0], baddr[1], 6'h18);
        both("dis_ready", rdy[0], rdy[1], 0);
        tick();
        both("dis_wr_ptr", wrp[0], wrp[1], 7);
        ptr_clear = 1;
        tick();
        ptr_clear = 0;
        tick();
        both("clr_wr_ptr", wrp[0], wrp[1], 0);
        both("clr_frames", fcnt[0], fcnt[1], 0);
        enable = 1;
        tick();
        s_valid = 1;
        repeat (2) tick();
        s_valid = 0; ptr_clear = 1;
        tick();
        ptr_clear = 0;
        repeat (2) tick();
        both("run_clr_ignored", wrp[0], wrp[1], 2);

        // Reset mid-write
        s_valid = 1; s_data = 32'hF00D;
        tick();
        both("pre_rst_en", ben[0], ben[1], 1);
        #1 rst = 1;
        #1;
        both("rst_async_en", ben[0], ben[1], 0);
        both("rst_async_we", bwe[0], bwe[1], 0);
        both("rst_async_wr_ptr", wrp[0], wrp[1], 0);
        both("rst_async_ready", rdy[0], rdy[1], 0);
        s_valid = 0;
        tick();
        rst = 0;
        tick();

        // Randomised traffic
        enable = 1;
        for (int c = 0; c < 600; c++) begin
            enable    = ($urandom_range(0, 24) != 0);
            s_valid   = ($urandom_range(0, 3) != 0);
            s_last    = ($urandom_range(0, 3) == 0);
            s_data    = $urandom;
            ptr_clear = ($urandom_range(0, 29) == 0);
            ovf_clear = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 5) == 0) rd_ptr = 4'($urandom_range(0, 15));
            tick();
        end
        idle_in();
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end
endmodule
